// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store stage.
// FSM encoding, funct3 codes, strobe masks and access checks.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_DONE
  } state_e;

  typedef logic [3:0] strb_t;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  localparam strb_t STRB_B = 4'b0001;
  localparam strb_t STRB_H = 4'b0011;
  localparam strb_t STRB_W = 4'b1111;

  function automatic logic op_illegal(
    input logic [2:0] op
  );
    return !(op inside {OP_B, OP_H, OP_W, OP_BU, OP_HU});
  endfunction

  function automatic logic op_misalign(
    input logic [2:0] op,
    input logic [1:0] off
  );
    logic r;
    r = 1'b0;
    if (op == OP_H || op == OP_HU)
      r = off[0];
    else if (op == OP_W)
      r = (off != 2'b00);
    return r;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Simple req/rsp memory port seen by the load/store stage.
// master = LSU side, slave = memory side.
interface lsu_if;
  import lsu_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  strb_t       wstrb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, we, addr, wdata, wstrb,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, we, addr, wdata, wstrb,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/lsu_fmt.sv
// Store lane replication / strobes and load extract / extend.
// Purely combinational; fed from the latched bundle.
module lsu_fmt
  import lsu_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_src2,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_wdata,
  output strb_t       o_wstrb,
  output logic [31:0] o_ldata
);

  logic [31:0] w_s;
  logic        w_b;
  logic        w_h;
  logic        w_sx;

  assign w_s  = i_rdata >> {i_off, 3'b000};
  assign w_b  = (i_op[1:0] == 2'b00);
  assign w_h  = (i_op[1:0] == 2'b01);
  assign w_sx = ~i_op[2];

  always_comb begin
    o_wdata = i_src2;
    o_wstrb = STRB_W;
    o_ldata = w_s;
    unique case (1'b1)
      w_b: begin
        o_wdata = {4{i_src2[7:0]}};
        o_wstrb = STRB_B << i_off;
        o_ldata = {{24{w_s[7] & w_sx}}, w_s[7:0]};
      end
      w_h: begin
        o_wdata = {2{i_src2[15:0]}};
        o_wstrb = STRB_H << i_off;
        o_ldata = {{16{w_s[15] & w_sx}}, w_s[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store stage: one memory request per instruction,
// registered result bundle toward write-back.
module lsu
  import lsu_pkg::*;
#(
  parameter bit MISALIGN_CHK = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_reg_wena,
  input  logic [1:0]  i_reg_sel,
  input  logic        i_MemWr,
  input  logic        i_MemRe,
  input  logic [2:0]  i_MemOp,
  input  logic [31:0] i_ALUout,
  input  logic [31:0] i_src2,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_inst,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_reg_wena,
  output logic [1:0]  o_reg_sel,
  output logic [31:0] o_ALUout,
  output logic [31:0] o_mem_rdata,
  output logic [31:0] o_pc,
  output logic [31:0] o_inst,
  output logic        o_err,
  output logic        o_mem_req_valid,
  input  logic        i_mem_req_ready,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wstrb,
  input  logic        i_mem_rsp_valid,
  input  logic [31:0] i_mem_rsp_rdata,
  input  logic        i_mem_rsp_err
);

  state_e      r_state;
  state_e      w_next;

  logic        r_reg_wena;
  logic [1:0]  r_reg_sel;
  logic [31:0] r_alu;
  logic [31:0] r_src2;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [2:0]  r_op;
  logic        r_we;
  logic        r_ld;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_mem;
  logic        w_bad;
  logic        w_acc;
  logic        w_rsp;
  strb_t       w_wstrb;
  logic [31:0] w_ldata;

  assign w_mem = i_MemWr | i_MemRe;
  assign w_bad = w_mem & (op_illegal(i_MemOp)
               | (MISALIGN_CHK & op_misalign(i_MemOp, i_ALUout[1:0])));
  assign w_acc = i_valid & (r_state == S_IDLE);
  assign w_rsp = i_mem_rsp_valid & (r_state == S_RESP);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (i_valid)
                w_next = (w_mem & ~w_bad) ? S_REQ : S_DONE;
      S_REQ:  if (i_mem_req_ready) w_next = S_RESP;
      S_RESP: if (i_mem_rsp_valid) w_next = S_DONE;
      S_DONE: if (i_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_reg_wena <= 1'b0;
      r_reg_sel  <= 2'b0;
      r_alu      <= 32'b0;
      r_src2     <= 32'b0;
      r_pc       <= 32'b0;
      r_inst     <= 32'b0;
      r_op       <= 3'b0;
      r_we       <= 1'b0;
      r_ld       <= 1'b0;
      r_rdata    <= 32'b0;
      r_err      <= 1'b0;
    end else if (w_acc) begin
      r_reg_wena <= i_reg_wena & ~w_bad;
      r_reg_sel  <= i_reg_sel;
      r_alu      <= i_ALUout;
      r_src2     <= i_src2;
      r_pc       <= i_pc;
      r_inst     <= i_inst;
      r_op       <= i_MemOp;
      r_we       <= i_MemWr;
      r_ld       <= i_MemRe & ~i_MemWr;
      r_rdata    <= 32'b0;
      r_err      <= w_bad;
    end else if (w_rsp) begin
      r_err <= i_mem_rsp_err;
      if (i_mem_rsp_err) begin
        r_reg_wena <= 1'b0;
        r_rdata    <= 32'b0;
      end else if (r_ld) begin
        r_rdata <= w_ldata;
      end
    end
  end

  lsu_fmt u_fmt (
    .i_op    (r_op),
    .i_off   (r_alu[1:0]),
    .i_src2  (r_src2),
    .i_rdata (i_mem_rsp_rdata),
    .o_wdata (o_mem_wdata),
    .o_wstrb (w_wstrb),
    .o_ldata (w_ldata)
  );

  // request lines follow the state register, so reset kills them at once
  assign o_mem_req_valid = (r_state == S_REQ);
  assign o_mem_we        = r_we;
  assign o_mem_addr      = r_alu;
  assign o_mem_wstrb     = r_we ? w_wstrb : 4'b0;

  assign o_ready     = (r_state == S_IDLE);
  assign o_valid     = (r_state == S_DONE);
  assign o_reg_wena  = r_reg_wena;
  assign o_reg_sel   = r_reg_sel;
  assign o_ALUout    = r_alu;
  assign o_mem_rdata = r_rdata;
  assign o_pc        = r_pc;
  assign o_inst      = r_inst;
  assign o_err       = r_err;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for the load/store stage.
// Expected bundles queued at issue, compared when o_valid rises.
module tb_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        reg_wena = 1'b0;
  logic [1:0]  reg_sel = 2'b0;
  logic        mwr = 1'b0;
  logic        mre = 1'b0;
  logic [2:0]  mop = 3'b0;
  logic [31:0] alu = 32'b0;
  logic [31:0] src2 = 32'b0;
  logic [31:0] pc = 32'b0;
  logic [31:0] inst = 32'b0;
  logic        ready = 1'b0;

  logic        o_ready;
  logic        o_valid;
  logic        o_reg_wena;
  logic [1:0]  o_reg_sel;
  logic [31:0] o_ALUout;
  logic [31:0] o_mem_rdata;
  logic [31:0] o_pc;
  logic [31:0] o_inst;
  logic        o_err;

  lsu_if mem ();

  always #5 clk = ~clk;

  lsu #(.MISALIGN_CHK(1'b1)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_valid         (valid),
    .o_ready         (o_ready),
    .i_reg_wena      (reg_wena),
    .i_reg_sel       (reg_sel),
    .i_MemWr         (mwr),
    .i_MemRe         (mre),
    .i_MemOp         (mop),
    .i_ALUout        (alu),
    .i_src2          (src2),
    .i_pc            (pc),
    .i_inst          (inst),
    .o_valid         (o_valid),
    .i_ready         (ready),
    .o_reg_wena      (o_reg_wena),
    .o_reg_sel       (o_reg_sel),
    .o_ALUout        (o_ALUout),
    .o_mem_rdata     (o_mem_rdata),
    .o_pc            (o_pc),
    .o_inst          (o_inst),
    .o_err           (o_err),
    .o_mem_req_valid (mem.req_valid),
    .i_mem_req_ready (mem.req_ready),
    .o_mem_we        (mem.we),
    .o_mem_addr      (mem.addr),
    .o_mem_wdata     (mem.wdata),
    .o_mem_wstrb     (mem.wstrb),
    .i_mem_rsp_valid (mem.rsp_valid),
    .i_mem_rsp_rdata (mem.rsp_rdata),
    .i_mem_rsp_err   (mem.rsp_err)
  );

  typedef struct {
    logic        err;
    logic        wena;
    logic [1:0]  sel;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] inst;
  } res_t;

  res_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic txn(
    input logic        wr,
    input logic        re,
    input logic [2:0]  op,
    input logic [31:0] addr,
    input logic [31:0] sdata,
    input logic        wen,
    input int          req_lat,
    input int          rsp_lat,
    input int          rdy_lat,
    input logic [31:0] rdata,
    input logic        rerr,
    input logic        x_req,
    input logic [31:0] x_wdata,
    input logic [3:0]  x_wstrb,
    input logic [31:0] x_rd,
    input logic        x_err
  );
    res_t e;
    int   t;
    check("idle_ready", o_ready, 1);
    valid    = 1'b1;
    mwr      = wr;
    mre      = re;
    mop      = op;
    alu      = addr;
    src2     = sdata;
    reg_wena = wen;
    reg_sel  = 2'($urandom);
    pc       = $urandom;
    inst     = $urandom;
    e.err    = x_err;
    e.wena   = wen & ~x_err;
    e.sel    = reg_sel;
    e.rdata  = x_rd;
    e.alu    = addr;
    e.pc     = pc;
    e.inst   = inst;
    sb.push_back(e);
    @(negedge clk);
    valid = 1'b0;
    alu   = $urandom;
    src2  = $urandom;
    inst  = $urandom;
    if (x_req) begin
      check("req_valid", mem.req_valid, 1);
      check("req_we", mem.we, wr);
      check("req_addr", mem.addr, addr);
      check("req_wstrb", mem.wstrb, x_wstrb);
      if (wr) check("req_wdata", mem.wdata, x_wdata);
      repeat (req_lat) begin
        @(negedge clk);
        check("hold_valid", mem.req_valid, 1);
        check("hold_addr", mem.addr, addr);
        check("hold_wstrb", mem.wstrb, x_wstrb);
        if (wr) check("hold_wdata", mem.wdata, x_wdata);
        check("busy_ready", o_ready, 0);
      end
      mem.req_ready = 1'b1;
      @(negedge clk);
      mem.req_ready = 1'b0;
      check("req_drop", mem.req_valid, 0);
      repeat (rsp_lat) @(negedge clk);
      mem.rsp_valid = 1'b1;
      mem.rsp_rdata = rdata;
      mem.rsp_err   = rerr;
      @(negedge clk);
      mem.rsp_valid = 1'b0;
      mem.rsp_err   = 1'b0;
      mem.rsp_rdata = $urandom;
    end else begin
      check("no_req", mem.req_valid, 0);
    end
    t = 0;
    while (!o_valid && t < 10) begin
      @(negedge clk);
      t++;
    end
    e = sb.pop_front();
    check("done_valid", o_valid, 1);
    if (o_valid) begin
      repeat (rdy_lat) begin
        @(negedge clk);
        check("stall_valid", o_valid, 1);
        check("stall_ready", o_ready, 0);
        check("stall_inst", o_inst, e.inst);
      end
      check("err", o_err, e.err);
      check("wena", o_reg_wena, e.wena);
      check("sel", o_reg_sel, e.sel);
      check("rdata", o_mem_rdata, e.rdata);
      check("alu", o_ALUout, e.alu);
      check("pc", o_pc, e.pc);
      check("inst", o_inst, e.inst);
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      check("bubble_valid", o_valid, 0);
      check("bubble_ready", o_ready, 1);
    end
  endtask

  initial begin
    mem.req_ready = 1'b0;
    mem.rsp_valid = 1'b0;
    mem.rsp_rdata = 32'b0;
    mem.rsp_err   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", o_ready, 1);
    check("rst_valid", o_valid, 0);
    check("rst_req", mem.req_valid, 0);
    check("rst_err", o_err, 0);
    check("rst_rdata", o_mem_rdata, 0);
    check("rst_wena", o_reg_wena, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // wr re op addr src2 wen reqL rspL rdyL rdata rerr | req wdata wstrb rd err
    txn(0, 1, OP_B,  32'h8000_0003, 32'h0, 1, 0, 0, 0,
        32'h80FF_0000, 0, 1, 32'h0, 4'b0000, 32'hFFFF_FF80, 0);
    txn(1, 0, OP_H,  32'h8000_0002, 32'h1234_ABCD, 0, 2, 1, 0,
        32'h5555_5555, 0, 1, 32'hABCD_ABCD, 4'b1100, 32'h0, 0);
    txn(0, 1, OP_W,  32'h8000_0001, 32'h0, 1, 0, 0, 0,
        32'h0, 0, 0, 32'h0, 4'b0000, 32'h0, 1);
    txn(0, 1, OP_W,  32'h8000_0010, 32'h0, 1, 5, 0, 0,
        32'hDEAD_BEEF, 1, 1, 32'h0, 4'b0000, 32'h0, 1);
    txn(0, 0, OP_W,  32'h0000_1235, 32'h0, 1, 0, 0, 3,
        32'h0, 0, 0, 32'h0, 4'b0000, 32'h0, 0);
    txn(0, 1, OP_HU, 32'h8000_0002, 32'h0, 1, 0, 2, 0,
        32'h8001_0000, 0, 1, 32'h0, 4'b0000, 32'h0000_8001, 0);
    txn(0, 1, OP_H,  32'h8000_0002, 32'h0, 1, 1, 0, 1,
        32'h8001_0000, 0, 1, 32'h0, 4'b0000, 32'hFFFF_8001, 0);
    txn(1, 0, OP_B,  32'h8000_0001, 32'h0000_00A5, 0, 0, 0, 0,
        32'h0, 0, 1, 32'hA5A5_A5A5, 4'b0010, 32'h0, 0);
    txn(0, 1, 3'b011, 32'h8000_0000, 32'h0, 1, 0, 0, 0,
        32'h0, 0, 0, 32'h0, 4'b0000, 32'h0, 1);
    txn(0, 1, OP_BU, 32'h8000_0000, 32'h0, 1, 0, 0, 0,
        32'h1234_56F0, 0, 1, 32'h0, 4'b0000, 32'h0000_00F0, 0);
    txn(1, 1, OP_W,  32'h8000_0008, 32'hCAFE_BABE, 0, 1, 1, 0,
        32'h0, 0, 1, 32'hCAFE_BABE, 4'b1111, 32'h0, 0);
    txn(0, 1, OP_W,  32'h8000_0010, 32'h0, 1, 0, 2, 2,
        32'hDEAD_BEEF, 0, 1, 32'h0, 4'b0000, 32'hDEAD_BEEF, 0);
    txn(1, 0, OP_H,  32'h8000_0003, 32'h0, 0, 0, 0, 0,
        32'h0, 0, 0, 32'h0, 4'b0000, 32'h0, 1);

    // reset asserted while a request is outstanding
    valid = 1'b1;
    mwr   = 1'b0;
    mre   = 1'b1;
    mop   = OP_W;
    alu   = 32'h8000_0020;
    @(negedge clk);
    valid = 1'b0;
    check("mid_req_valid", mem.req_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_req_drop", mem.req_valid, 0);
    check("rst_mid_valid", o_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", o_ready, 1);
    check("post_rst_valid", o_valid, 0);
    check("post_rst_req", mem.req_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
